// File: rtl/arb_mux.sv
// Round-robin N_IN-to-1 arbitrating mux with a registered output stage.
// Define ARB_MUX_SKID_EN for a 2-entry output buffer that removes the out_ready->in_ready path.
module arb_mux #(
  parameter int MUX_LEN = 32,
  parameter int N_IN    = 4,
  parameter int SEL_W   = $clog2(N_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_IN*MUX_LEN-1:0] in_data,
  input  logic [N_IN-1:0]         in_valid,
  output logic [N_IN-1:0]         in_ready,
  output logic [MUX_LEN-1:0]      out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(N_IN - 1);

  logic [SEL_W-1:0]   last_grant_q, last_grant_d;
  logic               found;
  logic [SEL_W-1:0]   winner;
  logic [MUX_LEN-1:0] win_data;
  int unsigned        cand;
  logic               space;
  logic               push;
  logic               pop;

  // Candidate index wraps at N_IN-1 so unused encodings are never searched.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = 0;
    for (int unsigned k = 1; k <= N_IN; k++) begin
      cand = 32'(last_grant_q) + k;
      if (cand >= N_IN) cand = cand - N_IN;
      if (!found && in_valid[SEL_W'(cand)]) begin
        found  = 1'b1;
        winner = SEL_W'(cand);
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (winner == SEL_W'(i)) win_data = in_data[i*MUX_LEN +: MUX_LEN];
    end
  end

  assign push = rst_n && found && space;
  assign pop  = out_valid && out_ready;

  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (push && (winner == SEL_W'(i))) in_ready[i] = 1'b1;
    end
  end

  assign last_grant_d = push ? winner : last_grant_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= LAST_RST;
    else        last_grant_q <= last_grant_d;
  end

`ifdef ARB_MUX_SKID_EN
  logic               v0_q, v0_d, v1_q, v1_d;
  logic [MUX_LEN-1:0] data0_q, data0_d, data1_q, data1_d;
  logic [SEL_W-1:0]   sel0_q, sel0_d, sel1_q, sel1_d;

  assign space = !v1_q;

  // Pop is applied first, then push lands in whichever slot is free afterwards.
  always_comb begin
    v0_d    = v0_q;
    v1_d    = v1_q;
    data0_d = data0_q;
    data1_d = data1_q;
    sel0_d  = sel0_q;
    sel1_d  = sel1_q;
    if (pop) begin
      if (v1_q) begin
        data0_d = data1_q;
        sel0_d  = sel1_q;
        v1_d    = 1'b0;
      end else begin
        v0_d = 1'b0;
      end
    end
    if (push) begin
      if (!v0_d) begin
        data0_d = win_data;
        sel0_d  = winner;
        v0_d    = 1'b1;
      end else begin
        data1_d = win_data;
        sel1_d  = winner;
        v1_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      data0_q <= '0;
      data1_q <= '0;
      sel0_q  <= '0;
      sel1_q  <= '0;
    end else begin
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      sel0_q  <= sel0_d;
      sel1_q  <= sel1_d;
    end
  end

  assign out_valid = v0_q;
  assign out_data  = data0_q;
  assign out_sel   = sel0_q;
`else
  logic               valid_q, valid_d;
  logic [MUX_LEN-1:0] data_q, data_d;
  logic [SEL_W-1:0]   sel_q, sel_d;

  assign space = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (pop) valid_d = 1'b0;
    if (push) begin
      valid_d = 1'b1;
      data_d  = win_data;
      sel_d   = winner;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_sel   = sel_q;
`endif

endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench for arb_mux against a queue-based round-robin reference model.
module tb_arb_mux;
  localparam int N = 4;
  localparam int W = 32;
`ifdef ARB_MUX_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_valid;
  logic           out_ready;

  int errors = 0;
  int checks = 0;

  int          mdl_last;
  logic [W-1:0] q_data[$];
  int          q_sel[$];
  int          last_push_ch;
  int          seq[N];

  arb_mux #(.MUX_LEN(W), .N_IN(N), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic void mdl_reset();
    mdl_last = N - 1;
    q_data.delete();
    q_sel.delete();
  endfunction

  function automatic int mdl_winner();
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (mdl_last + k) % N;
      if (in_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] mdl_ready();
    int  w;
    bit  sp;
    logic [N-1:0] r;
    w  = mdl_winner();
    sp = (CAP == 1) ? (q_data.size() == 0 || out_ready) : (q_data.size() < 2);
    r  = '0;
    if (w >= 0 && sp) r[w] = 1'b1;
    return r;
  endfunction

  // Applies the effect of the upcoming rising edge to the model, then advances.
  task automatic tick();
    logic [N-1:0] r;
    int w;
    r = mdl_ready();
    w = mdl_winner();
    last_push_ch = -1;
    if (q_data.size() > 0 && out_ready) begin
      void'(q_data.pop_front());
      void'(q_sel.pop_front());
    end
    if (r != '0) begin
      q_data.push_back(in_data[w*W +: W]);
      q_sel.push_back(w);
      mdl_last     = w;
      last_push_ch = w;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = 1'b0;
    in_data   = '0;
    mdl_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = '0; out_ready = 1'b0; in_data = '0;
    mdl_reset();
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== 2'd0 || in_ready !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%h sel=%0d ready=%b, want 0/0/0/0", out_valid, out_data, out_sel, in_ready);
    end
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      @(negedge clk);
      checks++;
      if (in_ready !== 4'b0000 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset c=%0d: ready=%b valid=%b, want 0000/0", c, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'hA0 + 32'(i);
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      logic [N-1:0] er;
      @(negedge clk);
      er = '0;
      er[c % N] = 1'b1;
      checks++;
      if (in_ready !== er) begin
        errors++;
        $display("FAIL rr_grant c=%0d: in_ready=%b, want %b", c, in_ready, er);
      end
      if (c > 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'((c - 1) % N) || out_data !== 32'hA0 + 32'((c - 1) % N)) begin
          errors++;
          $display("FAIL rr_out c=%0d: valid=%b sel=%0d data=%h, want 1/%0d/%h", c, out_valid, out_sel, out_data,
                   (c - 1) % N, 32'hA0 + 32'((c - 1) % N));
        end
      end
      tick();
    end
    in_valid = '0;
  endtask

  task automatic test_stall();
    apply_reset();
    in_data[2*W +: W] = 32'h1234;
    in_valid  = 4'b0100;
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 4'b0100 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_first: ready=%b valid=%b, want 0100/0", in_ready, out_valid);
    end
    tick();
    for (int c = 1; c <= 5; c++) begin
      logic [N-1:0] er;
      @(negedge clk);
      er = (CAP == 2 && c == 1) ? 4'b0100 : 4'b0000;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h1234 || out_sel !== 2'd2) begin
        errors++;
        $display("FAIL stall_hold c=%0d: valid=%b data=%h sel=%0d, want 1/1234/2", c, out_valid, out_data, out_sel);
      end
      checks++;
      if (in_ready !== er) begin
        errors++;
        $display("FAIL stall_ready c=%0d: in_ready=%b, want %b", c, in_ready, er);
      end
      tick();
    end
    in_valid  = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== (q_data.size() > 0) || (q_data.size() > 0 && out_data !== q_data[0])) begin
        errors++;
        $display("FAIL stall_drain c=%0d: valid=%b data=%h, want %0d entries", c, out_valid, out_data, q_data.size());
      end
      tick();
    end
  endtask

  task automatic test_fairness();
    apply_reset();
    in_data[1*W +: W] = 32'h11;
    in_data[3*W +: W] = 32'h33;
    out_ready = 1'b1;
    in_valid  = 4'b0010;
    @(negedge clk);
    checks++;
    if (in_ready !== 4'b0010) begin
      errors++;
      $display("FAIL fair_setup: in_ready=%b, want 0010", in_ready);
    end
    tick();
    in_valid = 4'b1010;
    @(negedge clk);
    checks++;
    if (in_ready !== 4'b1000 || out_sel !== 2'd1 || out_data !== 32'h11) begin
      errors++;
      $display("FAIL fair_ch3: ready=%b sel=%0d data=%h, want 1000/1/11", in_ready, out_sel, out_data);
    end
    tick();
    @(negedge clk);
    checks++;
    if (in_ready !== 4'b0010 || out_sel !== 2'd3 || out_data !== 32'h33) begin
      errors++;
      $display("FAIL fair_ch1: ready=%b sel=%0d data=%h, want 0010/3/33", in_ready, out_sel, out_data);
    end
    tick();
    in_valid = '0;
    @(negedge clk);
    checks++;
    if (out_sel !== 2'd1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL fair_last: sel=%0d valid=%b, want 1/1", out_sel, out_valid);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    in_data[0*W +: W] = 32'hDEAD0000;
    in_valid  = 4'b0001;
    out_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hDEAD0000) begin
      errors++;
      $display("FAIL rmid_fill: valid=%b data=%h, want 1/dead0000", out_valid, out_data);
    end
    #1 rst_n = 1'b0;
    mdl_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== 2'd0 || in_ready !== '0) begin
      errors++;
      $display("FAIL rmid_async: valid=%b data=%h sel=%0d ready=%b, want all 0", out_valid, out_data, out_sel, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    in_data[0*W +: W] = 32'hC0;
    in_data[1*W +: W] = 32'hC1;
    in_valid  = 4'b0011;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0001 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmid_prio: ready=%b valid=%b, want 0001/0", in_ready, out_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 32'hC0 || in_ready !== 4'b0010) begin
      errors++;
      $display("FAIL rmid_first: valid=%b sel=%0d data=%h ready=%b, want 1/0/c0/0010", out_valid, out_sel, out_data, in_ready);
    end
    tick();
    in_valid = '0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 32'hC1) begin
      errors++;
      $display("FAIL rmid_second: valid=%b sel=%0d data=%h, want 1/1/c1", out_valid, out_sel, out_data);
    end
    tick();
  endtask

  task automatic test_random();
    int bad;
    apply_reset();
    for (int i = 0; i < N; i++) seq[i] = 0;
    bad = 0;
    for (int c = 0; c < 10000; c++) begin
      logic [N-1:0] er;
      for (int i = 0; i < N; i++) in_data[i*W +: W] = (32'(i) << 24) | 32'(seq[i]);
      in_valid  = N'($urandom);
      out_ready = 1'($urandom);
      @(negedge clk);
      er = mdl_ready();
      checks++;
      if (in_ready !== er || $countones(in_ready) > 1) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rand_ready c=%0d: in_ready=%b, want %b", c, in_ready, er);
      end
      checks++;
      if (out_valid !== (q_data.size() > 0) ||
          (q_data.size() > 0 && (out_data !== q_data[0] || out_sel !== 2'(q_sel[0])))) begin
        errors++; bad++;
        if (bad < 10)
          $display("FAIL rand_out c=%0d: valid=%b sel=%0d data=%h, want %0d entries head sel=%0d data=%h", c,
                   out_valid, out_sel, out_data, q_data.size(), (q_sel.size() > 0) ? q_sel[0] : -1,
                   (q_data.size() > 0) ? q_data[0] : '0);
      end
      tick();
      if (last_push_ch >= 0) seq[last_push_ch]++;
    end
    in_valid  = '0;
    out_ready = 1'b1;
  endtask

  initial begin
    last_push_ch = -1;
    test_reset();
    test_round_robin();
    test_stall();
    test_fairness();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter MUX_LEN, default 32: data width per channel, >=1.
REQ-002 Parameter N_IN, default 4: input channel count, 2..16.
REQ-003 Parameter SEL_W, default $clog2(N_IN): width of out_sel.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_data  input  N_IN*MUX_LEN  channel i occupies bits [i*MUX_LEN +: MUX_LEN].
REQ-007 in_valid  input  N_IN  per-channel valid.
REQ-008 in_ready  output  N_IN  per-channel ready; at most one bit high per cycle.
REQ-009 out_data  output  MUX_LEN  registered selected data.
REQ-010 out_sel  output  SEL_W  index of the channel that supplied out_data.
REQ-011 out_valid  output  1  out_data/out_sel valid.
REQ-012 out_ready  input  1  downstream accept.

Function
REQ-013 Transfer on any port SHALL occur only in a cycle where valid and ready are both high at the rising edge.
REQ-014 Arbitration SHALL be round-robin: search starts at channel (last_grant+1) mod N_IN, wrapping; first channel with in_valid high wins.
REQ-015 last_grant SHALL update only on an input transfer, never on a lost or stalled request.
REQ-016 in_ready[i] SHALL be high only when i is the arbitration winner and the block can accept (space available); in_ready SHALL be all-zero when no in_valid is high.
REQ-017 Latency input transfer -> out_valid SHALL be exactly 1 cycle when the output stage is empty.
REQ-018 out_data/out_sel/out_valid SHALL come directly from flops; no combinational path from in_* to out_*.
REQ-019 Holding out_valid high with out_ready low SHALL keep out_data and out_sel stable until the transfer.
REQ-020 Same-cycle output transfer and input transfer SHALL both complete, sustaining 1 word/cycle with no bubble.
REQ-021 Data order per channel SHALL be preserved; no word dropped or duplicated.
REQ-022 in_valid deasserted by a loser without a transfer SHALL not alter state.
REQ-023 N_IN not a power of two: pointer wrap SHALL be at N_IN-1 -> 0, never to unused indices.

Reset
REQ-024 rst_n low SHALL asynchronously force out_valid=0, out_data=0, out_sel=0, in_ready=0, buffer empty, last_grant=N_IN-1 (channel 0 has first priority).
REQ-025 Reset mid-transfer SHALL discard all buffered words; first post-reset edge with rst_n high SHALL begin normal arbitration.

Configuration
REQ-026 Macro ARB_MUX_SKID_EN defined: 2-entry output buffer; in_ready SHALL depend only on registered state (high while <=1 entry occupied), breaking the out_ready->in_ready combinational path; full throughput retained.
REQ-027 ARB_MUX_SKID_EN undefined: single output register; space available = !out_valid | out_ready (combinational from out_ready); all other requirements unchanged.

Verification
REQ-028 Reset release, in_valid=4'b0000 -> in_ready=0, out_valid=0 for 10 cycles.
REQ-029 N_IN=4, all in_valid high continuously, out_ready=1, channel i data=32'hA0+i -> out_sel sequence 0,1,2,3,0,... one per cycle, out_data matching.
REQ-030 Only ch2 valid, data 32'h1234, out_ready=0 for 5 cycles -> out_valid=1 one cycle after transfer, out_data=32'h1234, out_sel=2 held stable; skid build accepts one more ch2 word, then in_ready[2]=0.
REQ-031 ch1 and ch3 valid, last_grant=1 -> ch3 granted; next cycle ch1 granted.
REQ-032 rst_n pulsed low while out_valid=1 and buffer full -> outputs zero immediately (before next clk edge), last_grant=3, buffered words never appear.
REQ-033 Random valid/ready (50%) 10k cycles, both macro settings -> scoreboard: per-channel in-order, no loss, no duplicate, at most one in_ready bit high.
